// File: rtl/branch_cond_resolver.sv
// branch_cond_resolver: resolves SPARC Bicc conditions from PSR or forwarded ALU flags,
// stalls the front end on in-flight cc writes and sequences the delay-slot annul decision.
`default_nettype none

module branch_cond_resolver #(
  parameter int MAX_CC_WAIT = 4,
  parameter int CNT_W       = 3
) (
  input  logic       clk,
  input  logic       Clr,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  input  logic       br_annul,
  input  logic [3:0] psr_flags,
  input  logic [3:0] alu_flags,
  input  logic       alu_flags_we,
  input  logic       cc_pending,
  input  logic       slot_adv,
  output logic       stall,
  output logic       br_taken,
  output logic       annul_slot,
  output logic       busy,
  output logic       cc_timeout,
  output logic       dcti_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CC = 2'd1,
    SLOT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CC_WAIT - 1);

  state_t           state, state_nx;
  logic [3:0]       cond_q, cond_nx;
  logic             annul_q, annul_nx;
  logic             dec_q, dec_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             taken_nx, dcti_nx;

  logic             res_go, res_annul, res_taken;
  logic [3:0]       res_cond, res_flags, eff_flags;

  // Flag order: [3]=N, [2]=C, [1]=Z, [0]=V
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, cy, z, v;
    n  = f[3];
    cy = f[2];
    z  = f[1];
    v  = f[0];
    case (c)
      4'h0:    cond_eval = 1'b0;
      4'h1:    cond_eval = z;
      4'h2:    cond_eval = z | (n ^ v);
      4'h3:    cond_eval = n ^ v;
      4'h4:    cond_eval = cy | z;
      4'h5:    cond_eval = cy;
      4'h6:    cond_eval = n;
      4'h7:    cond_eval = v;
      4'h8:    cond_eval = 1'b1;
      4'h9:    cond_eval = ~z;
      4'hA:    cond_eval = ~(z | (n ^ v));
      4'hB:    cond_eval = ~(n ^ v);
      4'hC:    cond_eval = ~(cy | z);
      4'hD:    cond_eval = ~cy;
      4'hE:    cond_eval = ~n;
      default: cond_eval = ~v;
    endcase
  endfunction

  assign eff_flags = alu_flags_we ? alu_flags : psr_flags;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx   = state;
    cond_nx    = cond_q;
    annul_nx   = annul_q;
    dec_nx     = dec_q;
    cnt_nx     = cnt;
    taken_nx   = 1'b0;
    dcti_nx    = 1'b0;
    stall      = 1'b0;
    annul_slot = 1'b0;
    cc_timeout = 1'b0;
    res_go     = 1'b0;
    res_cond   = cond_q;
    res_annul  = annul_q;
    res_flags  = eff_flags;
    res_taken  = 1'b0;

    case (state)
      IDLE: begin
        if (br_valid) begin
          res_cond  = br_cond;
          res_annul = br_annul;
          if (cc_pending && !alu_flags_we) begin
            stall    = 1'b1;
            state_nx = WAIT_CC;
            cond_nx  = br_cond;
            annul_nx = br_annul;
            cnt_nx   = '0;
          end else begin
            res_go = 1'b1;
          end
        end
      end
      WAIT_CC: begin
        stall   = 1'b1;
        dcti_nx = br_valid;
        if (alu_flags_we || !cc_pending) begin
          res_go = 1'b1;
        end else if (cnt == CNT_LAST) begin
          // Watchdog expired: fall back to whatever the PSR holds now
          res_go     = 1'b1;
          res_flags  = psr_flags;
          cc_timeout = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      SLOT: begin
        dcti_nx = br_valid;
        if (slot_adv) begin
          annul_slot = dec_q;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (res_go) begin
      res_taken = cond_eval(res_cond, res_flags);
      taken_nx  = res_taken;
      dec_nx    = res_annul & (~res_taken | (res_cond == 4'h8));
      cnt_nx    = '0;
      state_nx  = SLOT;
    end
  end

  always_ff @(posedge clk or negedge Clr) begin
    if (!Clr) begin
      state    <= IDLE;
      cond_q   <= 4'h0;
      annul_q  <= 1'b0;
      dec_q    <= 1'b0;
      cnt      <= '0;
      br_taken <= 1'b0;
      dcti_err <= 1'b0;
    end else begin
      state    <= state_nx;
      cond_q   <= cond_nx;
      annul_q  <= annul_nx;
      dec_q    <= dec_nx;
      cnt      <= cnt_nx;
      br_taken <= taken_nx;
      dcti_err <= dcti_nx;
    end
  end

endmodule

`default_nettype wire
